seg_scan_sched: RTL

Display scan scheduler for the 8-digit multiplexed seven-segment display. It owns the display's digit strobes. Client logic writes digit patterns into a shadow buffer, and the block drives one digit at a time with a blanking guard between digits. On a commit request, the shadow buffer is copied to the active buffer only at a frame boundary, so a frame never shows a partial update.

---
 rtl/seg_scan_sched.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_sched.sv
// seg_scan_sched -- scan scheduler for an 8-digit multiplexed seven-segment
// display. Client writes land in a shadow buffer. A commit copies shadow to
// active only at the frame boundary, which is the last SHOW cycle of digit 7.
// Optional build macro: SEG_DIM_EN enables per-visit PWM dimming via brightness.
module seg_scan_sched #(
    parameter int DWELL = 1000,
    parameter int BLANK = 50
) (
    input  logic       CLK,
    input  logic       N_Reset,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit,
    input  logic [2:0] brightness,
    output logic       busy,
    output logic       commit_ack,
    output logic       frame_tick,
    output logic [7:0] SEG_COM,
    output logic [7:0] SEG_DATA
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? (BLANK - 1) : 0);
    // With no blank phase, the scan starts directly in SHOW of digit 0.
    // Its first cycle after reset is dark because the outputs still hold
    // their reset values, but the frame timing is unchanged.
    localparam state_t RESET_ST = (BLANK > 0) ? ST_BLANK : ST_SHOW;

    state_t      state_r, state_nx_s;
    logic [2:0]  idx_r, idx_nx_s;
    logic [CW-1:0] cnt_r, cnt_nx_s;

    logic [7:0]  shadow_r    [8];
    logic [7:0]  active_r    [8];
    logic [7:0]  active_nx_s [8];

    logic        pending_r;
    logic        tick_r;
    logic [7:0]  com_r;
    logic [7:0]  data_r;

    logic        copy_s;
    logic        lit_nx_s;
    logic        tick_nx_s;
    logic [7:0]  com_nx_s;
    logic [7:0]  data_nx_s;

    // tick_r is high exactly during the boundary cycle. A commit arriving in
    // that cycle is applied in the same cycle.
    assign copy_s     = tick_r & (pending_r | commit);

    assign busy       = pending_r;
    assign frame_tick = tick_r;
    // The only combinational input-to-output path: a commit raised in the
    // boundary cycle must be acknowledged in the cycle that applies it.
    assign commit_ack = copy_s;
    assign SEG_COM    = com_r;
    assign SEG_DATA   = data_r;

    // Next scan position: BLANK/SHOW phase, digit index and phase cycle count.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        cnt_nx_s   = cnt_r + CW'(1);
        case (state_r)
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_nx_s = ST_SHOW;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = ST_BLANK;
                end
            end
            ST_SHOW: begin
                if (cnt_r == DWELL_LAST) begin
                    idx_nx_s   = idx_r + 3'd1;
                    cnt_nx_s   = '0;
                    state_nx_s = (BLANK > 0) ? ST_BLANK : ST_SHOW;
                end else begin
                    state_nx_s = ST_SHOW;
                end
            end
            default: begin
                state_nx_s = RESET_ST;
                idx_nx_s   = 3'd0;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // Active contents as seen from the next cycle, so a digit 0 lit right
    // after the boundary already shows freshly committed data.
    always_comb begin
        if (copy_s) begin
            active_nx_s = shadow_r;
        end else begin
            active_nx_s = active_r;
        end
    end

`ifdef SEG_DIM_EN
    logic [2:0]  bright_r;
    logic [2:0]  bright_eff_s;
    logic [31:0] lit_lim_s;

    // Digit is lit only for the first (brightness+1)/8 of each visit.
    // Brightness is latched on SHOW entry.
    always_comb begin
        if ((state_nx_s == ST_SHOW) && (cnt_nx_s == '0)) begin
            bright_eff_s = brightness;
        end else begin
            bright_eff_s = bright_r;
        end
        lit_lim_s = ((32'(bright_eff_s) + 32'd1) * 32'(DWELL)) >> 3;
        lit_nx_s  = (state_nx_s == ST_SHOW) && (32'(cnt_nx_s) < lit_lim_s);
    end

    // Hold the brightness sampled at SHOW entry for the rest of the visit.
    always_ff @(posedge CLK or negedge N_Reset) begin
        if (!N_Reset) begin
            bright_r <= 3'd0;
        end else begin
            bright_r <= bright_eff_s;
        end
    end
`else
    logic unused_brightness_s;
    assign unused_brightness_s = ^brightness;

    // Without dimming every SHOW cycle is fully lit.
    always_comb begin
        lit_nx_s = (state_nx_s == ST_SHOW);
    end
`endif

    // Output values for the next cycle, derived from the next scan position.
    always_comb begin
        tick_nx_s = (state_nx_s == ST_SHOW) && (idx_nx_s == 3'd7) &&
                    (cnt_nx_s == DWELL_LAST);
        if (lit_nx_s) begin
            com_nx_s  = ~(8'd1 << idx_nx_s);
            data_nx_s = active_nx_s[idx_nx_s];
        end else begin
            com_nx_s  = 8'hFF;
            data_nx_s = 8'h00;
        end
    end

    // Scan position registers.
    always_ff @(posedge CLK or negedge N_Reset) begin
        if (!N_Reset) begin
            state_r <= RESET_ST;
            idx_r   <= 3'd0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Shadow buffer: client writes only.
    always_ff @(posedge CLK or negedge N_Reset) begin
        if (!N_Reset) begin
            for (int i = 0; i < 8; i++) begin
                shadow_r[i] <= 8'h00;
            end
        end else if (wr_en) begin
            shadow_r[wr_addr] <= wr_data;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Active buffer: loaded from the pre-edge shadow only at the frame boundary.
    always_ff @(posedge CLK or negedge N_Reset) begin
        if (!N_Reset) begin
            for (int i = 0; i < 8; i++) begin
                active_r[i] <= 8'h00;
            end
        end else begin
            active_r <= active_nx_s;
        end
    end

    // Pending commit flag. Repeated commits merge, and the flag clears on copy.
    always_ff @(posedge CLK or negedge N_Reset) begin
        if (!N_Reset) begin
            pending_r <= 1'b0;
        end else if (copy_s) begin
            pending_r <= 1'b0;
        end else if (commit) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Registered display outputs and frame tick.
    always_ff @(posedge CLK or negedge N_Reset) begin
        if (!N_Reset) begin
            com_r  <= 8'hFF;
            data_r <= 8'h00;
            tick_r <= 1'b0;
        end else begin
            com_r  <= com_nx_s;
            data_r <= data_nx_s;
            tick_r <= tick_nx_s;
        end
    end

endmodule
